// File: rtl/mul_limb_seq.sv
// Sequential multi-limb unsigned multiplier: one W x W partial product per cycle,
// accumulated into a 2*N*W-bit result, with an optional low-half-only mode.
module mul_limb_seq #(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_lo,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N*W-1:0] y,
    output logic             busy
);

    localparam int H  = N * W;
    localparam int P  = 2 * N * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [H-1:0]    a_q;
    logic [H-1:0]    b_q;
    logic            lo_q;
    logic [P-1:0]    acc;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [W-1:0]    a_l;
    logic [W-1:0]    b_l;
    logic [P-1:0]    pp;
    logic [P-1:0]    sum;
    logic [P-1:0]    y_fin;
    logic            skip;
    logic            last;
    logic            accept;

    assign accept = in_valid && (state == IDLE);

    always_comb begin
        a_l   = a_q[int'(i)*W +: W];
        b_l   = b_q[int'(j)*W +: W];
        pp    = (P'(a_l) * P'(b_l)) << (W * (int'(i) + int'(j)));
        skip  = lo_q && ((int'(i) + int'(j)) >= N);
        last  = (int'(i) == N - 1) && (int'(j) == N - 1);
        sum   = acc + (skip ? '0 : pp);
        y_fin = sum;
        // Terms kept in low-half mode can still spill above H bits; drop them.
        if (lo_q) y_fin[P-1:H] = '0;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            lo_q  <= 1'b0;
            acc   <= '0;
            y     <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                lo_q <= mode_lo;
                acc  <= '0;
                y    <= '0;
                i    <= '0;
                j    <= '0;
            end else if (state == MUL) begin
                acc <= sum;
                if (int'(j) == N - 1) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
                if (last) y <= y_fin;
            end
        end
    end

endmodule

// File: tb/tb_mul_limb_seq.sv
// Directed bench for mul_limb_seq (W=16, N=2) with an expected-result queue.
module tb_mul_limb_seq;

    localparam int W = 16;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          mode_lo;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   y;
    logic          busy;

    logic [63:0]   exp_q[$];
    int            total = 0;
    int            passed = 0;
    int            failed = 0;

    mul_limb_seq #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_lo(mode_lo), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(logic [31:0] x, logic [31:0] z, logic lo);
        logic [63:0] p;
        p = {32'h0, x} * {32'h0, z};
        if (lo) p = {32'h0, p[31:0]};
        return p;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(logic [31:0] x, logic [31:0] z, logic lo);
        @(negedge clk);
        a = x; b = z; mode_lo = lo; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, y, e);
        end
    endtask

    task automatic run_op(string tag, logic [31:0] x, logic [31:0] z,
                          logic lo, logic [63:0] exp);
        int lat;
        accept(x, z, lo);
        exp_q.push_back(exp);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_out(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        check_result(tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int last_c;
        int nacc;
        int nout;
        logic seen;
        logic [63:0] e;

        rst = 1'b1; in_valid = 1'b1; mode_lo = 1'b0;
        a = 32'h5; b = 32'h7; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", y, 64'd0);

        run_op("full", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        run_op("align1", 32'h00010000, 32'h00020003, 1'b0, 64'h0000000200030000);
        run_op("align2", 32'h00000003, 32'h00050000, 1'b0, 64'h00000000000F0000);
        run_op("lo_half", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
        run_op("lo_mix", 32'h12345678, 32'h9ABCDEF0, 1'b1,
               model(32'h12345678, 32'h9ABCDEF0, 1'b1));

        out_ready = 1'b0;
        accept(32'h12345678, 32'h9ABCDEF0, 1'b0);
        e = 64'h12345678 * 64'h9ABCDEF0;
        exp_q.push_back(e);
        wait_out(lat);
        chk("bp_lat", 64'(lat), 64'd4);
        check_result("bp_y");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            chk("bp_hold_y", y, e);
            chk("bp_hold_ov", 64'(out_valid), 64'd1);
            chk("bp_hold_ir", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release", 64'(in_ready), 64'd1);
        chk("bp_y_kept", y, e);

        accept(32'h0000FFFF, 32'h0000FFFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_y", y, 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("abort_no_out", 64'(seen), 64'd0);
        run_op("after_abort", 32'd2, 32'd3, 1'b0, 64'd6);

        last_c = -1; nacc = 0; nout = 0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; mode_lo = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                check_result("b2b_y");
                nout++;
            end
            a = $urandom; b = $urandom;
            if (in_ready) begin
                exp_q.push_back(model(a, b, 1'b0));
                if (last_c >= 0) chk("b2b_interval", 64'(c - last_c), 64'd6);
                last_c = c;
                nacc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin
                check_result("b2b_drain_y");
                nout++;
            end
            @(negedge clk);
        end
        chk("b2b_count", 64'(nout), 64'(nacc));
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
